sr_latch_bank_ctrl: RTL and testbench

Sequencing controller and two-port arbiter for a bank of N gated NAND SR latch cells. Two requesters issue set/reset/read operations on one addressed cell; the block grants them round-robin, drives the cell's S/R/en pins with a safe setup/pulse/hold sequence, and reports completion with the sampled Q. The S=R=1 condition never reaches a cell while en is high, so the latch bank stays out of its forbidden state.

---
 rtl/sr_latch_bank_ctrl.sv | 156 +++++++++++++++
 tb/tb_sr_latch_bank_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank_ctrl.sv
// Sequencer and two-port round-robin arbiter for a bank of gated NAND SR latches.
// Optional macro SRL_CTRL_READBACK_EN: sample Q after set/reset and flag mismatches.
module sr_latch_bank_ctrl #(
  parameter int N = 8,
  parameter int EN_PULSE = 2,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [1:0]    req1_op,
  output logic [N-1:0]  lat_s,
  output logic [N-1:0]  lat_r,
  output logic [N-1:0]  lat_en,
  input  logic [N-1:0]  lat_q,
  output logic          busy,
  output logic          done,
  output logic          done_id,
  output logic          done_q,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK, FIN} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_r;
  logic [1:0]    op_r;
  logic          id_r;
  logic          last;

  logic          arb_ok, gnt0, gnt1, acc, illegal, q_smp;
  logic [AW-1:0] a_in;
  logic [1:0]    o_in;
  logic [N-1:0]  sel_in, sel_r;

  // FIN counts as idle so a new request is accepted in the done cycle.
  assign arb_ok = (state == IDLE) || (state == FIN);
  assign gnt0   = arb_ok & req0_valid & (~req1_valid | last);
  assign gnt1   = arb_ok & req1_valid & (~req0_valid | ~last);
  assign acc    = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign a_in    = gnt1 ? req1_addr : req0_addr;
  assign o_in    = gnt1 ? req1_op : req0_op;
  assign illegal = (o_in == 2'b11) || (32'(a_in) >= N);
  assign sel_in  = N'(1) << a_in;
  assign sel_r   = N'(1) << addr_r;
  assign q_smp   = lat_q[addr_r];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_r  <= '0;
      op_r    <= '0;
      id_r    <= 1'b0;
      last    <= 1'b1;
      lat_s   <= '0;
      lat_r   <= '0;
      lat_en  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      done_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= 1'b0;
      done_id <= 1'b0;
      done_q  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (acc) begin
            id_r   <= gnt1;
            last   <= gnt1;
            addr_r <= a_in;
            op_r   <= illegal ? 2'b11 : o_in;
            if (illegal) begin
              state   <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              done_id <= gnt1;
              err     <= 1'b1;
            end else if (o_in == 2'b00) begin
              state <= CHECK;
              busy  <= 1'b1;
            end else begin
              state <= SETUP;
              busy  <= 1'b1;
              lat_s <= (o_in == 2'b01) ? sel_in : '0;
              lat_r <= (o_in == 2'b10) ? sel_in : '0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETUP: begin
          state  <= PULSE;
          lat_en <= sel_r;
          cnt    <= 4'd1;
        end
        PULSE: begin
          if (cnt == 4'(EN_PULSE)) begin
            state  <= HOLD;
            lat_en <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          lat_s <= '0;
          lat_r <= '0;
`ifdef SRL_CTRL_READBACK_EN
          state <= CHECK;
`else
          // Without readback the expected value is reported directly.
          state   <= FIN;
          busy    <= 1'b0;
          done    <= 1'b1;
          done_id <= id_r;
          done_q  <= (op_r == 2'b01);
`endif
        end
        CHECK: begin
          state   <= FIN;
          busy    <= 1'b0;
          done    <= 1'b1;
          done_id <= id_r;
          done_q  <= q_smp;
          err     <= (op_r != 2'b00) && (q_smp != (op_r == 2'b01));
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Latch-safety invariants: never S=R=1, one cell at a time, en only in PULSE.
  a_no_sr:   assert property (@(posedge clk) disable iff (rst) (lat_s & lat_r) == '0);
  a_oh_s:    assert property (@(posedge clk) disable iff (rst) $onehot0(lat_s));
  a_oh_r:    assert property (@(posedge clk) disable iff (rst) $onehot0(lat_r));
  a_oh_en:   assert property (@(posedge clk) disable iff (rst) $onehot0(lat_en));
  a_en_puls: assert property (@(posedge clk) disable iff (rst) (lat_en != '0) |-> (state == PULSE));
  a_sr_stab: assert property (@(posedge clk) disable iff (rst)
                              (state == PULSE && $past(state) == PULSE) |-> ($stable(lat_s) && $stable(lat_r)));
endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl with a behavioural latch-cell model.
module tb_sr_latch_bank_ctrl;
`ifdef SRL_CTRL_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int DONE_SR = 3 + 2 + RB;

  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [2:0] req0_addr = 0, req1_addr = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [7:0] lat_s, lat_r, lat_en, lat_q;
  logic busy, done, done_id, done_q, err;

  logic [7:0] cells = 8'h00, fmask = 8'h00, fval = 8'h00;

  logic b_valid = 0, b_ready, b_r1_ready;
  logic [2:0] b_addr = 0;
  logic [1:0] b_op = 0;
  logic [5:0] b_lat_s, b_lat_r, b_lat_en;
  logic b_busy, b_done, b_done_id, b_done_q, b_err;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  // Gated latch: follows S/R while en is high, holds otherwise; fmask forces Q.
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (lat_en[i]) cells[i] <= lat_s[i] ? 1'b1 : (lat_r[i] ? 1'b0 : cells[i]);
  assign lat_q = (cells & ~fmask) | (fval & fmask);

  sr_latch_bank_ctrl #(.N(8), .EN_PULSE(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_op(req1_op),
    .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en), .lat_q(lat_q),
    .busy(busy), .done(done), .done_id(done_id), .done_q(done_q), .err(err));

  sr_latch_bank_ctrl #(.N(6), .EN_PULSE(1)) u_odd (
    .clk(clk), .rst(rst),
    .req0_valid(b_valid), .req0_ready(b_ready), .req0_addr(b_addr), .req0_op(b_op),
    .req1_valid(1'b0), .req1_ready(b_r1_ready), .req1_addr(3'd0), .req1_op(2'd0),
    .lat_s(b_lat_s), .lat_r(b_lat_r), .lat_en(b_lat_en), .lat_q(6'd0),
    .busy(b_busy), .done(b_done), .done_id(b_done_id), .done_q(b_done_q), .err(b_err));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Requester 0 set/reset from IDLE, checked cycle by cycle up to done.
  task automatic run_sr(input logic [1:0] op, input logic [2:0] a, input logic eq, input logic ee,
                        input string nm);
    logic [7:0] sel;
    sel = 8'h01 << a;
    @(negedge clk);
    req0_valid = 1; req0_op = op; req0_addr = a;
    #1 chk({nm, " ready0"}, req0_ready, 1'b1);
    @(posedge clk); #1 req0_valid = 0;
    for (int c = 1; c <= DONE_SR; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d lat_s", nm, c), lat_s, (op == 2'b01 && c <= 4) ? sel : 8'h00);
      chk($sformatf("%s c%0d lat_r", nm, c), lat_r, (op == 2'b10 && c <= 4) ? sel : 8'h00);
      chk($sformatf("%s c%0d lat_en", nm, c), lat_en, (c == 2 || c == 3) ? sel : 8'h00);
      chk($sformatf("%s c%0d busy", nm, c), busy, c < DONE_SR);
      chk($sformatf("%s c%0d done", nm, c), done, c == DONE_SR);
    end
    chk({nm, " done_id"}, done_id, 1'b0);
    chk({nm, " done_q"}, done_q, eq);
    chk({nm, " err"}, err, ee);
  endtask

  logic [1:0] exp_rdy [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
  logic       exp_dn  [7] = '{0, 0, 1, 0, 1, 0, 1};
  logic       exp_id  [7] = '{0, 0, 0, 0, 1, 0, 0};
  logic       exp_q   [7] = '{0, 0, 0, 0, 1, 0, 0};

  initial begin
    @(negedge clk);
    chk("rst ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst lat", {lat_s, lat_r, lat_en}, 24'h0);
    chk("rst status", {busy, done, done_id, done_q, err}, 5'b0);
    rst = 0;

    // Set cell 3 from requester 0.
    run_sr(2'b01, 3'd3, 1'b1, 1'b0, "set3");

    // Contention from reset, both requesters holding reads back to back.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    req0_valid = 1; req0_op = 2'b00; req0_addr = 3'd1;
    req1_valid = 1; req1_op = 2'b00; req1_addr = 3'd3;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("arb c%0d ready", c), {req1_ready, req0_ready}, exp_rdy[c]);
      chk($sformatf("arb c%0d done", c), done, exp_dn[c]);
      if (exp_dn[c]) begin
        chk($sformatf("arb c%0d done_id", c), done_id, exp_id[c]);
        chk($sformatf("arb c%0d done_q", c), done_q, exp_q[c]);
      end
      if (c == 4) begin
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
      end
    end

    // Illegal op from requester 1, and out-of-range address on the N=6 instance.
    @(negedge clk);
    req1_valid = 1; req1_op = 2'b11; req1_addr = 3'd2;
    b_valid = 1; b_op = 2'b01; b_addr = 3'd7;
    #1 chk("ill ready1", req1_ready, 1'b1);
    chk("oor ready", b_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("ill done", {done, err, done_id, done_q}, 4'b1110);
    chk("ill lat", {lat_s, lat_r, lat_en, 7'd0, busy}, 32'h0);
    chk("oor done", {b_done, b_err, b_done_id, b_done_q}, 4'b1100);
    chk("oor lat", {b_lat_s, b_lat_r, b_lat_en, b_busy}, 19'h0);
    @(negedge clk);
    chk("ill done2", done, 1'b0);
    chk("oor lat2", {b_lat_s, b_lat_r, b_lat_en, b_done}, 19'h0);

    // Reset cell 5 whose Q is stuck high.
    fmask = 8'h20; fval = 8'h20;
    run_sr(2'b10, 3'd5, RB == 1, RB == 1, "rst5");
    fmask = 8'h00;

    // Reset during PULSE aborts the op; pointer returns to favouring req0.
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b01; req0_addr = 3'd6;
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("abort pulse en", lat_en, 8'h40);
    #2 rst = 1;
    #1 chk("abort lat", {lat_s, lat_r, lat_en}, 24'h0);
    chk("abort busy", busy, 1'b0);
    @(negedge clk); rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort nodone c%0d", c), done, 1'b0);
    end
    req0_valid = 1; req0_op = 2'b00; req0_addr = 3'd6;
    req1_valid = 1; req1_op = 2'b11; req1_addr = 3'd0;
    #1 chk("post ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("post c1 busy", busy, 1'b1);
    @(negedge clk);
    chk("post done", {done, done_id, done_q, err}, 4'b1000);
    chk("cell6 kept", cells[6], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
